rr_grant_ctrl: RTL

- Round-robin arbiter controller for N_REQ requesters sharing one resource.
- Samples the request vector, picks one winner with rotating priority and holds the grant until release or timeout.
- Drives a one-hot grant vector and a binary grant index; a timeout pulse flags forced releases.
- Sits between the requesters and the shared-resource mux/decoder in the arbiter lab design.

---
 rtl/arb_pkg.sv | 24 ++
 rtl/rr_prio_pick.sv | 39 +++
 rtl/rr_grant_ctrl.sv | 116 +++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin grant controller.
// Holds the FSM state encoding, default sizing and one-hot conversion.
package arb_pkg;

  localparam int N_REQ_DEF    = 8;
  localparam int MAX_HOLD_DEF = 16;
  localparam int OH_MAX       = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } arb_state_t;

  function automatic logic [OH_MAX-1:0] idx2oh(
    input logic [3:0] idx
  );
    logic [OH_MAX-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/rr_prio_pick.sv
// Rotating-priority winner picker: first set request at or above ptr,
// wrapping to bit 0, via a double-width masked scan.
module rr_prio_pick
  import arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic             any_req_o,
  output logic [IDX_W-1:0] win_o
);

  logic [N_REQ-1:0]   mask;
  logic [2*N_REQ-1:0] dbl;
  logic [IDX_W-1:0]   pos;

  always_comb begin
    mask = '0;
    for (int k = 0; k < N_REQ; k++) begin
      mask[k] = (IDX_W'(k) >= ptr_i);
    end
  end

  // Upper copy is unmasked, so it catches the wrapped candidates.
  assign dbl = {req_i, req_i & mask};

  always_comb begin
    pos = '0;
    for (int i = 2*N_REQ-1; i >= 0; i--) begin
      if (dbl[i]) pos = IDX_W'(i);
    end
  end

  assign any_req_o = |req_i;
  assign win_o     = pos;

endmodule

// File: rtl/rr_grant_ctrl.sv
// Round-robin grant controller: grants one requester, holds until
// release or MAX_HOLD timeout, then inserts a one-cycle gap.
module rr_grant_ctrl
  import arb_pkg::*;
#(
  parameter int N_REQ    = N_REQ_DEF,
  parameter int IDX_W    = $clog2(N_REQ),
  parameter int MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [N_REQ-1:0] req_i,
  output logic [N_REQ-1:0] grants_o,
  output logic [IDX_W-1:0] gnt_idx_o,
  output logic             gnt_valid_o,
  output logic             timeout_o
);

  localparam int CW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD+1) : 1;
  localparam bit HOLD_EN = (MAX_HOLD != 0);
  localparam logic [CW-1:0] HOLD_LAST =
    HOLD_EN ? CW'(MAX_HOLD-1) : '0;
  localparam logic [CW-1:0] CNT_SAT = '1;

  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [N_REQ-1:0] grants_q, grants_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             valid_q, valid_d;
  logic             to_q, to_d;

  logic             any_req;
  logic [IDX_W-1:0] win;

  rr_prio_pick #(
    .N_REQ(N_REQ),
    .IDX_W(IDX_W)
  ) u_pick (
    .req_i    (req_i),
    .ptr_i    (ptr_q),
    .any_req_o(any_req),
    .win_o    (win)
  );

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    grants_d = grants_q;
    idx_d    = idx_q;
    valid_d  = valid_q;
    to_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (enable && any_req) begin
          idx_d    = win;
          grants_d = N_REQ'(idx2oh(4'(win)));
          valid_d  = 1'b1;
          cnt_d    = '0;
          state_d  = GRANT;
        end
      end
      GRANT: begin
        // Release wins over a coincident timeout.
        if (!req_i[idx_q]) begin
          grants_d = '0;
          valid_d  = 1'b0;
          ptr_d    = idx_q + IDX_W'(1);
          state_d  = GAP;
        end else if (HOLD_EN && cnt_q == HOLD_LAST) begin
          grants_d = '0;
          valid_d  = 1'b0;
          to_d     = 1'b1;
          ptr_d    = idx_q + IDX_W'(1);
          state_d  = GAP;
        end else if (cnt_q != CNT_SAT) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      cnt_q    <= '0;
      grants_q <= '0;
      idx_q    <= '0;
      valid_q  <= 1'b0;
      to_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      grants_q <= grants_d;
      idx_q    <= idx_d;
      valid_q  <= valid_d;
      to_q     <= to_d;
    end
  end

  assign grants_o    = grants_q;
  assign gnt_idx_o   = idx_q;
  assign gnt_valid_o = valid_q;
  assign timeout_o   = to_q;

endmodule
